// File: rtl/sphere_pair_loader_if.sv
// Stream handshake bundle for the sphere-pair loader:
// float words in, parallel fixed-point packet out.
interface sphere_pair_loader_if #(
  parameter int FW = 32,
  parameter int NW = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_float;
  logic              out_valid;
  logic              out_ready;
  logic [FW*NW-1:0]  out_mag;
  logic [NW-1:0]     out_sign;
  logic [NW-1:0]     out_ovf;

  modport master (
    output in_valid,
    output in_float,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_mag,
    input  out_sign,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_float,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_mag,
    output out_sign,
    output out_ovf
  );
endinterface

// File: rtl/sphere_pair_loader.sv
// Gathers an 8-word float sphere pair, converts each word to
// sign/magnitude fixed point and holds the packet for collision.
module float_to_fixed #(
  parameter int FW = 32,
  parameter int FF = 16
) (
  input  logic [31:0]   i_float,
  output logic [FW-1:0] o_mag,
  output logic          o_sign,
  output logic          o_ovf
);
  localparam int I = FW - FF;

  logic [7:0]  w_e;
  logic [31:0] w_m32;
  logic [31:0] w_sh;
  int          w_sd;

  assign w_e   = i_float[30:23];
  assign w_m32 = {1'b1, i_float[22:0], 8'h00};
  // Left-aligned mantissa: bit 31 carries weight 2^(I-1)
  assign w_sd  = 127 + I - 1 - int'(w_e);
  assign w_sh  = w_m32 >> w_sd[4:0];

  always_comb begin
    o_mag  = '0;
    o_sign = i_float[31];
    o_ovf  = 1'b0;
    if (w_e == 8'h00) begin
      o_sign = 1'b0;
    end else if (w_e == 8'hFF || w_sd < 0) begin
      o_mag = '1;
      o_ovf = 1'b1;
    end else if (w_sd > 31) begin
      o_mag = '0;
    end else begin
      o_mag = w_sh[31 -: FW];
    end
  end
endmodule

module sphere_pair_loader #(
  parameter int FIXED_WIDTH      = 32,
  parameter int FIXED_FRACTIONAL = 16,
  parameter int NUM_WORDS        = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 abort,
  sphere_pair_loader_if.slave  bus,
  output logic                 busy
);
  localparam int FW = FIXED_WIDTH;
  localparam int NW = NUM_WORDS;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    COLLECT,
    FLUSH,
    HOLD
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_stg_valid;
  logic [IW-1:0]    r_stg_idx;
  logic [FW-1:0]    r_stg_mag;
  logic             r_stg_sign;
  logic             r_stg_ovf;
  logic [FW*NW-1:0] r_mag;
  logic [NW-1:0]    r_sign;
  logic [NW-1:0]    r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [FW-1:0]    w_mag;
  logic             w_sign;
  logic             w_ovf;

  float_to_fixed #(
    .FW (FW),
    .FF (FIXED_FRACTIONAL)
  ) u_f2f (
    .i_float (bus.in_float),
    .o_mag   (w_mag),
    .o_sign  (w_sign),
    .o_ovf   (w_ovf)
  );

  assign bus.in_ready  = (r_state == COLLECT) && !abort;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_mag   = r_mag;
  assign bus.out_sign  = r_sign;
  assign bus.out_ovf   = r_ovf;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_last   = (r_idx == IW'(NW - 1));

  assign busy = (r_state != COLLECT) ||
                (r_idx != '0) ||
                r_stg_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= COLLECT;
      r_idx       <= '0;
      r_stg_valid <= 1'b0;
      r_stg_idx   <= '0;
      r_stg_mag   <= '0;
      r_stg_sign  <= 1'b0;
      r_stg_ovf   <= 1'b0;
    end else if (abort) begin
      r_state     <= COLLECT;
      r_idx       <= '0;
      r_stg_valid <= 1'b0;
    end else begin
      r_stg_valid <= w_accept;
      if (w_accept) begin
        r_stg_idx  <= r_idx;
        r_stg_mag  <= w_mag;
        r_stg_sign <= w_sign;
        r_stg_ovf  <= w_ovf;
        r_idx      <= w_last ? '0 : r_idx + 1'b1;
      end
      unique case (r_state)
        COLLECT: if (w_accept && w_last) r_state <= FLUSH;
        FLUSH:   r_state <= HOLD;
        HOLD:    if (bus.out_ready) r_state <= COLLECT;
        default: r_state <= COLLECT;
      endcase
    end
  end

  // A dropped stage word never reaches its slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mag  <= '0;
      r_sign <= '0;
      r_ovf  <= '0;
    end else if (r_stg_valid && !abort) begin
      r_mag[r_stg_idx*FW +: FW] <= r_stg_mag;
      r_sign[r_stg_idx]         <= r_stg_sign;
      r_ovf[r_stg_idx]          <= r_stg_ovf;
    end
  end
endmodule

// File: tb/tb_sphere_pair_loader.sv
// Directed-vector and scoreboard bench for sphere_pair_loader.
// Drives on posedge+1, samples on negedge.
module tb_sphere_pair_loader;
  localparam int FW = 32;
  localparam int NW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic abort = 1'b0;
  logic busy;

  sphere_pair_loader_if #(.FW(FW), .NW(NW)) bus ();

  sphere_pair_loader #(
    .FIXED_WIDTH      (FW),
    .FIXED_FRACTIONAL (16),
    .NUM_WORDS        (NW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .abort   (abort),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f;
    logic [31:0] mag;
    logic        sign;
    logic        ovf;
  } vec_t;

  vec_t tbl [24];
  int checks = 0;
  int errors = 0;
  logic [34:0] q [$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void setv(int i, logic [31:0] f,
                               logic [31:0] m, logic s, logic o);
    tbl[i].f = f;
    tbl[i].mag = m;
    tbl[i].sign = s;
    tbl[i].ovf = o;
  endfunction

  // Independent model: mantissa scaled by 2^(e-127+16-23)
  function automatic logic [34:0] model(logic [31:0] w);
    int e;
    int sh;
    longint mant;
    longint v;
    e = int'(w[30:23]);
    if (e == 0) return '0;
    if (e == 255) return {1'b1, w[31], 32'hFFFF_FFFF};
    mant = longint'({1'b1, w[22:0]});
    sh = e - 134;
    if (sh >= 0) v = mant << sh;
    else if (-sh >= 40) v = 0;
    else v = mant >> (-sh);
    if (v >= 64'h1_0000_0000)
      return {1'b1, w[31], 32'hFFFF_FFFF};
    return {1'b0, w[31], v[31:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] m;
    logic [7:0]  e;
    int sel;
    m = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0) e = 8'd0;
    else if (sel == 1) e = 8'd255;
    else if (sel == 2) e = 8'($urandom_range(100, 112));
    else e = 8'($urandom_range(112, 145));
    return {m[31], e, m[22:0]};
  endfunction

  task automatic put(input logic [31:0] w, input int bubbles);
    int n;
    repeat (bubbles) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_float = w;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("put_timeout", 64'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int base);
    for (int i = 0; i < NW; i++) put(tbl[base+i].f, 0);
  endtask

  task automatic check_pkt(input int base, input string tag);
    for (int i = 0; i < NW; i++)
      chk($sformatf("%s_slot%0d", tag, i),
          {bus.out_ovf[i], bus.out_sign[i], bus.out_mag[i*FW +: FW]},
          {tbl[base+i].ovf, tbl[base+i].sign, tbl[base+i].mag});
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) chk({tag, "_timeout"}, 64'(bus.out_valid), 1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_float = '0;
    bus.out_ready = 1'b0;

    setv(0,  32'h3F800000, 32'h00010000, 0, 0);
    setv(1,  32'hC0200000, 32'h00028000, 1, 0);
    setv(2,  32'h3F000000, 32'h00008000, 0, 0);
    setv(3,  32'h00000000, 32'h00000000, 0, 0);
    setv(4,  32'h3F800000, 32'h00010000, 0, 0);
    setv(5,  32'h3F800000, 32'h00010000, 0, 0);
    setv(6,  32'h3F800000, 32'h00010000, 0, 0);
    setv(7,  32'h3F800000, 32'h00010000, 0, 0);
    setv(8,  32'h47000000, 32'h80000000, 0, 0);
    setv(9,  32'h47800000, 32'hFFFFFFFF, 0, 1);
    setv(10, 32'h7F800000, 32'hFFFFFFFF, 0, 1);
    setv(11, 32'hFFC00000, 32'hFFFFFFFF, 1, 1);
    setv(12, 32'h80000000, 32'h00000000, 0, 0);
    setv(13, 32'h33800000, 32'h00000000, 0, 0);
    setv(14, 32'hB3800000, 32'h00000000, 1, 0);
    setv(15, 32'h42C80000, 32'h00640000, 0, 0);
    setv(16, 32'h3F800001, 32'h00010000, 0, 0);
    setv(17, 32'h477FFFFF, 32'hFFFFFF00, 0, 0);
    setv(18, 32'h37800000, 32'h00000001, 0, 0);
    setv(19, 32'h37000000, 32'h00000000, 0, 0);
    setv(20, 32'hBF800000, 32'h00010000, 1, 0);
    setv(21, 32'h3FC00000, 32'h00018000, 0, 0);
    setv(22, 32'hC7000000, 32'h80000000, 1, 0);
    setv(23, 32'h00000001, 32'h00000000, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);

    // nominal packet and two-cycle latency
    @(posedge clk);
    #1;
    send_pkt(0);
    @(negedge clk);
    chk("lat_t1_valid", 64'(bus.out_valid), 0);
    chk("lat_t1_busy", 64'(busy), 1);
    @(negedge clk);
    chk("lat_t2_valid", 64'(bus.out_valid), 1);
    check_pkt(0, "nom");

    // backpressure in HOLD
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.out_valid), 1);
      chk("hold_in_ready", 64'(bus.in_ready), 0);
      check_pkt(0, "hold");
    end
    take();
    @(negedge clk);
    chk("rel_in_ready", 64'(bus.in_ready), 1);
    chk("rel_out_valid", 64'(bus.out_valid), 0);
    chk("rel_busy", 64'(busy), 0);
    check_pkt(0, "stale");

    // conversion limits
    @(posedge clk);
    #1;
    for (int p = 1; p < 3; p++) begin
      send_pkt(p * NW);
      wait_valid("lim");
      check_pkt(p * NW, $sformatf("lim%0d", p));
      take();
    end

    // reset mid-packet
    for (int i = 0; i < 3; i++) put(tbl[i].f, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_mag", 64'(bus.out_mag[63:0]), 0);
    chk("mid_rst_mag_hi", 64'(bus.out_mag[255:192]), 0);
    chk("mid_rst_sign", 64'(bus.out_sign), 0);
    chk("mid_rst_ovf", 64'(bus.out_ovf), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 1);
    chk("mid_rst_busy2", 64'(busy), 0);

    // abort after 3 accepts, word in abort cycle dropped
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) put(tbl[8+i].f, 0);
    abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_float = 32'h40000000;
    @(negedge clk);
    chk("abort_in_ready", 64'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 0);
    @(posedge clk);
    #1;
    send_pkt(0);
    wait_valid("abt");
    check_pkt(0, "abt");

    // abort coinciding with the output handshake
    @(negedge clk);
    abort = 1'b1;
    take();
    abort = 1'b0;
    @(negedge clk);
    chk("abt_hs_valid", 64'(bus.out_valid), 0);
    chk("abt_hs_in_ready", 64'(bus.in_ready), 1);
    chk("abt_hs_busy", 64'(busy), 0);

    // random bubbles and stalls against a scoreboard
    @(posedge clk);
    #1;
    fork
      begin
        logic [31:0] w;
        for (int k = 0; k < 100 * NW; k++) begin
          w = rand_word();
          q.push_back(model(w));
          put(w, $urandom_range(0, 2));
        end
      end
      begin
        logic [34:0] exp;
        for (int p = 0; p < 100; p++) begin
          wait_valid("rnd");
          for (int i = 0; i < NW; i++) begin
            exp = (q.size() > 0) ? q.pop_front() : '1;
            chk($sformatf("rnd_p%0d_s%0d", p, i),
                {bus.out_ovf[i], bus.out_sign[i],
                 bus.out_mag[i*FW +: FW]}, exp);
          end
          repeat ($urandom_range(0, 3)) @(negedge clk);
          take();
        end
      end
    join
    @(negedge clk);
    chk("rnd_drained", 64'(q.size()), 0);
    chk("rnd_busy", 64'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
